pattern_loader: RTL and testbench

Host-side serial loader for the pattern buffer bank. It accepts a buffer address and a stream of `BUFSIZE` bytes over a valid/ready byte interface. It serialises them MSB-first onto the bank's `sclk`/`sin`/`ssel`/`saddr` serial port, and captures the bank's `sout` so each load also reads back the buffer's previous contents. It sits between the configuration host and the pattern buffer bank and is the only driver of the bank's serial port.

---
 rtl/pattern_pkg.sv | 22 ++
 rtl/pattern_loader_bit_shifter.sv | 71 +++++++
 rtl/pattern_loader.sv | 186 ++++++++++++++++++
 tb/tb_pattern_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared constants, address fields and loader state encoding for the pattern
// buffer bank and its serial loader.
package pattern_pkg;

  localparam int unsigned BUFSIZE = 27;
  localparam int unsigned NOBUFS  = 8;
  localparam int unsigned ADDR_W  = $clog2(NOBUFS);

  localparam logic [ADDR_W-1:0] SEQ1ADR    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] SEQ2ADR    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] SEQCTRLADR = ADDR_W'(NOBUFS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    FETCH,
    LOW,
    HIGH,
    HOLD
  } ld_state_e;

endpackage

// File: rtl/pattern_loader_bit_shifter.sv
// Per-bit datapath of the loader: tx/rx shift registers, bit counter and the
// sclk half-period timer.
module bit_shifter #(
  parameter int unsigned DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cnt_en,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       shift,
  input  logic       sample,
  input  logic       sout,
  output logic       phase_end,
  output logic [2:0] bit_cnt,
  output logic       tx_msb_next,
  output logic [7:0] rx_byte
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_q, div_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [2:0]    bit_q, bit_d;

  assign phase_end = cnt_en && (div_q == CW'(DIV - 1));

  always_comb begin
    div_d = div_q;
    tx_d  = tx_q;
    rx_d  = rx_q;
    bit_d = bit_q;
    if (!cnt_en || phase_end) begin
      div_d = '0;
    end else begin
      div_d = div_q + CW'(1);
    end
    if (load) begin
      tx_d = load_data;
    end else if (shift) begin
      tx_d = {tx_q[6:0], 1'b0};
    end
    if (shift) begin
      bit_d = bit_q + 3'd1;
    end
    if (sample) begin
      rx_d = {rx_q[6:0], sout};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      tx_q  <= '0;
      rx_q  <= '0;
      bit_q <= '0;
    end else begin
      div_q <= div_d;
      tx_q  <= tx_d;
      rx_q  <= rx_d;
      bit_q <= bit_d;
    end
  end

  // Lets the top register sin from the value tx will hold next cycle.
  assign tx_msb_next = tx_d[7];
  assign bit_cnt     = bit_q;
  assign rx_byte     = rx_q;

endmodule

// File: rtl/pattern_loader.sv
// Host-side serial loader: streams one frame of bytes MSB-first into a
// pattern buffer and returns the buffer's previous contents.
module pattern_loader
  import pattern_pkg::*;
#(
  parameter int unsigned BUFSIZE = pattern_pkg::BUFSIZE,
  parameter int unsigned NOBUFS  = pattern_pkg::NOBUFS,
  parameter int unsigned DIV     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [$clog2(NOBUFS)-1:0] addr,
  output logic                      busy,
  input  logic [7:0]                wr_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  output logic [7:0]                rd_data,
  output logic                      rd_valid,
  output logic                      done,
  output logic                      sclk,
  output logic                      sin,
  output logic                      ssel,
  output logic [$clog2(NOBUFS)-1:0] saddr,
  input  logic                      sout
);

  localparam int unsigned AW = $clog2(NOBUFS);

  ld_state_e state_q, state_d;
  logic          hold_last_q, hold_last_d;
  logic [4:0]    byte_q, byte_d;
  logic [AW-1:0] saddr_q, saddr_d;
  logic          sclk_q, sclk_d;
  logic          sin_q, sin_d;
  logic          ssel_q, ssel_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic       cnt_en, load, shift, sample;
  logic       phase_end, tx_msb_next;
  logic [2:0] bit_cnt;
  logic [7:0] rx_byte;

  bit_shifter #(
    .DIV (DIV)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .cnt_en      (cnt_en),
    .load        (load),
    .load_data   (wr_data),
    .shift       (shift),
    .sample      (sample),
    .sout        (sout),
    .phase_end   (phase_end),
    .bit_cnt     (bit_cnt),
    .tx_msb_next (tx_msb_next),
    .rx_byte     (rx_byte)
  );

  always_comb begin
    state_d     = state_q;
    hold_last_d = hold_last_q;
    byte_d      = byte_q;
    saddr_d     = saddr_q;
    cnt_en      = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
    sample      = 1'b0;
    rd_valid    = 1'b0;
    wr_ready    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          saddr_d = addr;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_en = 1'b1;
        if (phase_end) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          load    = 1'b1;
          state_d = LOW;
        end
      end
      LOW: begin
        cnt_en = 1'b1;
        if (phase_end) begin
          sample  = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        cnt_en = 1'b1;
        if (phase_end) begin
          shift = 1'b1;
          if (bit_cnt == 3'd7) begin
            rd_valid = 1'b1;
            if (byte_q == 5'(BUFSIZE - 1)) begin
              byte_d  = '0;
              state_d = HOLD;
            end else begin
              byte_d  = byte_q + 5'd1;
              state_d = FETCH;
            end
          end else begin
            state_d = LOW;
          end
        end
      end
      HOLD: begin
        // DIV cycles with ssel held, then one extra cycle carrying done.
        if (!hold_last_q) begin
          cnt_en = 1'b1;
          if (phase_end) begin
            hold_last_d = 1'b1;
          end
        end else begin
          hold_last_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == IDLE) begin
      saddr_d = '0;
    end

    // Port registers are loaded from the next state so they line up with it.
    sclk_d = (state_d == HIGH);
    busy_d = (state_d != IDLE);
    done_d = (state_d == HOLD) && hold_last_d;
    ssel_d = busy_d && !done_d;
    if (state_d == LOW) begin
      sin_d = tx_msb_next;
    end else if (state_d == IDLE) begin
      sin_d = 1'b0;
    end else begin
      sin_d = sin_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_last_q <= 1'b0;
      byte_q      <= '0;
      saddr_q     <= '0;
      sclk_q      <= 1'b0;
      sin_q       <= 1'b0;
      ssel_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_last_q <= hold_last_d;
      byte_q      <= byte_d;
      saddr_q     <= saddr_d;
      sclk_q      <= sclk_d;
      sin_q       <= sin_d;
      ssel_q      <= ssel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sclk    = sclk_q;
  assign sin     = sin_q;
  assign ssel    = ssel_q;
  assign saddr   = saddr_q;
  assign rd_data = rx_byte;

endmodule

// File: tb/tb_pattern_loader.sv
// Scoreboard bench for pattern_loader with a behavioural buffer bank on the
// serial port and a per-address frame memory as reference.
module tb_pattern_loader;

  localparam int unsigned BUFSIZE   = 27;
  localparam int unsigned NOBUFS    = 8;
  localparam int unsigned DIV       = 2;
  localparam int          FRAME_CYC = 2 * DIV + BUFSIZE * (16 * DIV + 1);
  localparam int          STALL     = 50;
  localparam int          TMO       = 5000;

  logic       clk = 1'b0;
  logic       rst, start, wr_valid, sout;
  logic [2:0] addr;
  logic [7:0] wr_data;
  logic       busy, wr_ready, rd_valid, done, sclk, sin, ssel;
  logic [7:0] rd_data;
  logic [2:0] saddr;

  always #5 clk = ~clk;

  pattern_loader #(
    .BUFSIZE (BUFSIZE),
    .NOBUFS  (NOBUFS),
    .DIV     (DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .addr     (addr),
    .busy     (busy),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .done     (done),
    .sclk     (sclk),
    .sin      (sin),
    .ssel     (ssel),
    .saddr    (saddr),
    .sout     (sout)
  );

  // Behavioural buffer bank: one 216-bit shift register per address.
  logic                     bank_init = 1'b0;
  logic [8*BUFSIZE-1:0]     bank [NOBUFS];
  always @(posedge sclk or posedge bank_init) begin
    if (bank_init) begin
      for (int a = 0; a < NOBUFS; a++) bank[a] <= {BUFSIZE{8'hA5}};
    end else if (ssel) begin
      bank[saddr] <= {bank[saddr][8*BUFSIZE-2:0], sin};
    end
  end
  assign sout = bank[saddr][8*BUFSIZE-1];

  int         n_chk = 0, n_fail = 0;
  int         exp_q[$];
  bit         bit_q[$];
  int         mem [NOBUFS][BUFSIZE];
  logic [7:0] frame_buf [BUFSIZE];
  logic [2:0] cur_addr = '0;
  int         cyc = 0, done_cnt = 0, done_cyc = 0, saddr_bad = 0;
  logic       sclk_prev = 1'b0, sin_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: readback scoreboard, serial bit order, saddr stability, done.
  always @(negedge clk) begin
    int e;
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (e >= 0) chk("rd_data", 32'(rd_data), 32'(e));
      end
    end
    if (sclk && !sclk_prev) begin
      chk("sin_stable", 32'(sin), 32'(sin_prev));
      if (bit_q.size() == 0) chk("sclk_unexpected", 32'd1, 32'd0);
      else chk("sin_bit", 32'(sin), 32'(bit_q.pop_front()));
    end
    if (busy && saddr !== cur_addr) saddr_bad++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    sclk_prev = sclk;
    sin_prev  = sin;
  end

  task automatic run_frame(input logic [2:0] a, input int stall_after,
                           input int poke_after, input int abort_after);
    int t0, n, dc0, bad0, stall_bad;
    bit is_stall;
    dc0 = done_cnt; bad0 = saddr_bad; stall_bad = 0;
    cur_addr = a;
    @(posedge clk); #1;
    start = 1'b1; addr = a;
    @(posedge clk); #1;
    start = 1'b0; addr = 3'($urandom);
    t0 = cyc;
    for (int i = 0; i < BUFSIZE; i++) begin
      is_stall = (stall_after >= 0) && (i == stall_after + 1);
      wr_data  = frame_buf[i];
      wr_valid = !is_stall;
      n = 0;
      do begin @(negedge clk); n++; end while (!wr_ready && n < TMO);
      if (n >= TMO) begin
        chk("fetch_timeout", 32'd1, 32'd0);
        wr_valid = 1'b0;
        return;
      end
      if (is_stall) begin
        for (int k = 0; k < STALL; k++) begin
          @(posedge clk); @(negedge clk);
          if (sclk || !ssel || !wr_ready) stall_bad++;
        end
        wr_valid = 1'b1;
      end
      @(posedge clk); #1;
      exp_q.push_back(mem[a][i]);
      mem[a][i] = int'(frame_buf[i]);
      for (int b = 7; b >= 0; b--) bit_q.push_back(frame_buf[i][b]);
      if (i == poke_after) begin
        start = 1'b1; addr = 3'd2;
        fork begin @(posedge clk); #1 start = 1'b0; end join_none
      end
      if (i == abort_after) begin
        wr_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_serial_idle", {29'd0, ssel, sclk, busy}, 32'd0);
        repeat (20) @(negedge clk);
        chk("rst_no_done", 32'(done_cnt - dc0), 32'd0);
        exp_q.delete();
        bit_q.delete();
        for (int j = 0; j < BUFSIZE; j++) mem[a][j] = -1;
        return;
      end
    end
    wr_valid = 1'b0;
    n = 0;
    while (done_cnt == dc0 && n < TMO) begin @(negedge clk); n++; end
    chk("done_seen", 32'(done_cnt != dc0), 32'd1);
    chk("frame_cycles", 32'(done_cyc - t0), 32'(FRAME_CYC + (stall_after >= 0 ? STALL : 0)));
    repeat (5) @(negedge clk);
    chk("done_once", 32'(done_cnt - dc0), 32'd1);
    chk("saddr_stable", 32'(saddr_bad - bad0), 32'd0);
    chk("rd_drained", 32'(exp_q.size()), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    if (stall_after >= 0) chk("stall_idle", 32'(stall_bad), 32'd0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < BUFSIZE; i++) frame_buf[i] = 8'($urandom);
  endtask

  initial begin
    int quiet;
    rst = 1'b1; start = 1'b0; addr = '0; wr_valid = 1'b1; wr_data = 8'h55;
    #1 bank_init = 1'b1;
    #1 bank_init = 1'b0;
    for (int a = 0; a < NOBUFS; a++)
      for (int i = 0; i < BUFSIZE; i++) mem[a][i] = 'hA5;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {11'd0, busy, wr_ready, rd_data, rd_valid, done, sclk, sin, ssel, saddr}, 32'd0);
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      if (wr_ready || busy || rd_valid || done || sclk || sin || ssel || saddr != 0) quiet++;
    end
    chk("idle_quiet", 32'(quiet), 32'd0);
    wr_valid = 1'b0;

    for (int i = 0; i < BUFSIZE; i++) frame_buf[i] = 8'(i);
    run_frame(3'd5, -1, -1, -1);

    for (int i = 0; i < BUFSIZE; i++) frame_buf[i] = 8'h3C;
    run_frame(3'd1, -1, -1, -1);
    fill_random();
    run_frame(3'd1, -1, -1, -1);
    fill_random();
    run_frame(3'd1, 3, -1, -1);

    fill_random();
    run_frame(3'd3, -1, -1, 10);
    fill_random();
    run_frame(3'd3, -1, -1, -1);
    fill_random();
    run_frame(3'd3, -1, -1, -1);

    fill_random();
    run_frame(3'd6, -1, 5, -1);

    for (int f = 0; f < 2; f++) begin
      fill_random();
      run_frame(3'($urandom), (f == 1) ? int'($urandom_range(0, 20)) : -1, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
